// File: rtl/bfp_bw_tracker_if.sv
// rtl/bfp_bw_tracker_if.sv - sample stream bundle feeding the bit-width tracker (sample_ovf present with BFP_BW_TRACKER_OVF_EN)
interface bfp_bw_tracker_if #(
  parameter int FFT_DW = 16
);
  logic                     sample_valid;
  logic signed [FFT_DW-1:0] sample_re;
  logic signed [FFT_DW-1:0] sample_im;
  logic                     sample_last;
`ifdef BFP_BW_TRACKER_OVF_EN
  logic                     sample_ovf;
`endif

  modport master (
    output sample_valid,
    output sample_re,
    output sample_im,
`ifdef BFP_BW_TRACKER_OVF_EN
    output sample_ovf,
`endif
    output sample_last
  );

  modport slave (
    input sample_valid,
    input sample_re,
    input sample_im,
`ifdef BFP_BW_TRACKER_OVF_EN
    input sample_ovf,
`endif
    input sample_last
  );
endinterface

// File: rtl/bfp_bw_tracker.sv
// rtl/bfp_bw_tracker.sv - per-pass maximum sample bit-width tracker for block floating point FFT (option: BFP_BW_TRACKER_OVF_EN)
module bfp_bw_tracker #(
  parameter int FFT_DW            = 16,
  parameter int FFT_MAX_BIT_WIDTH = 5,
  parameter int FFT_STAGES        = 9
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_start,
  bfp_bw_tracker_if.slave              s,
  output logic                         init,
  output logic [FFT_MAX_BIT_WIDTH-1:0] bw_init,
  output logic                         update,
  output logic [FFT_MAX_BIT_WIDTH-1:0] bw_new,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int PCW = $clog2(FFT_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ADC, STAGE} state_t;

  state_t                       state;
  logic [PCW-1:0]               pass_cnt;

  logic                         a_valid;
  logic                         a_last;
  logic                         a_ovf;
  logic [FFT_MAX_BIT_WIDTH-1:0] a_width;

  logic [FFT_MAX_BIT_WIDTH-1:0] run_max;
  logic                         run_ovf;
  logic                         b_last;

  logic                         accept;
  logic                         ovf_in;
  logic [FFT_MAX_BIT_WIDTH-1:0] samp_w;
  logic [FFT_MAX_BIT_WIDTH-1:0] base_max;
  logic                         base_ovf;
  logic [FFT_MAX_BIT_WIDTH-1:0] next_max;
  logic [FFT_MAX_BIT_WIDTH-1:0] rep_val;

  // Magnitude bits excluding sign: negative values are measured on their complement
  function automatic logic [FFT_MAX_BIT_WIDTH-1:0] mag_width(input logic [FFT_DW-1:0] x);
    logic [FFT_DW-1:0] m;
    m = x[FFT_DW-1] ? ~x : x;
    mag_width = '0;
    for (int i = 0; i < FFT_DW; i++) begin
      if (m[i]) mag_width = FFT_MAX_BIT_WIDTH'(i + 1);
    end
  endfunction

`ifdef BFP_BW_TRACKER_OVF_EN
  assign ovf_in = s.sample_ovf;
`else
  assign ovf_in = 1'b0;
`endif

  // A sample coinciding with frame_start belongs to the aborted frame and is dropped
  assign accept = s.sample_valid && (state != IDLE) && !frame_start;

  // Sample width, pass-boundary restart of the running max, and the report value
  always_comb begin
    samp_w   = (mag_width(s.sample_re) > mag_width(s.sample_im)) ?
               mag_width(s.sample_re) : mag_width(s.sample_im);
    base_max = b_last ? '0 : run_max;
    base_ovf = b_last ? 1'b0 : run_ovf;
    next_max = (a_width > base_max) ? a_width : base_max;
    rep_val  = run_ovf ? FFT_MAX_BIT_WIDTH'(FFT_DW) : run_max;
  end

  // Stage A: register width and flags of every accepted sample; frame_start flushes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      a_ovf   <= 1'b0;
      a_width <= '0;
    end else begin
      a_valid <= accept;
      if (accept) begin
        a_width <= samp_w;
        a_last  <= s.sample_last;
        a_ovf   <= ovf_in;
      end
    end
  end

  // Stage B running max plus the pass FSM; b_last marks that run_max now holds a finished pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pass_cnt   <= '0;
      run_max    <= '0;
      run_ovf    <= 1'b0;
      b_last     <= 1'b0;
      init       <= 1'b0;
      update     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bw_init    <= '0;
      bw_new     <= '0;
    end else begin
      init       <= 1'b0;
      update     <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        state    <= ADC;
        pass_cnt <= '0;
        busy     <= 1'b1;
        run_max  <= '0;
        run_ovf  <= 1'b0;
        b_last   <= 1'b0;
      end else begin
        if (a_valid) begin
          run_max <= next_max;
          run_ovf <= base_ovf | a_ovf;
          b_last  <= a_last;
        end else begin
          run_max <= base_max;
          run_ovf <= base_ovf;
          b_last  <= 1'b0;
        end
        if (b_last) begin
          case (state)
            ADC: begin
              init     <= 1'b1;
              bw_init  <= rep_val;
              state    <= STAGE;
              pass_cnt <= PCW'(1);
            end
            STAGE: begin
              update <= 1'b1;
              bw_new <= rep_val;
              if (pass_cnt == PCW'(FFT_STAGES)) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                pass_cnt <= pass_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bfp_bw_tracker.sv
// tb/tb_bfp_bw_tracker.sv - directed self-checking bench for bfp_bw_tracker
module tb_bfp_bw_tracker;
  localparam int DW = 16;
  localparam int BW = 5;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          init, update, busy, frame_done;
  logic [BW-1:0] bw_init, bw_new;

  bfp_bw_tracker_if #(.FFT_DW(DW)) sif ();

  bfp_bw_tracker #(
    .FFT_DW(DW),
    .FFT_MAX_BIT_WIDTH(BW),
    .FFT_STAGES(ST)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .s(sif),
    .init(init),
    .bw_init(bw_init),
    .update(update),
    .bw_new(bw_new),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_init = 0, n_update = 0, n_done = 0, both_hi = 0;
  int            init_cyc = 0, upd_cyc = 0, done_cyc = 0;
  logic          busy_at_done = 1'b1;
  logic [BW-1:0] upd_val [0:15];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (init) begin
      n_init   <= n_init + 1;
      init_cyc <= cyc;
    end
    if (update) begin
      upd_val[n_update % 16] <= bw_new;
      n_update <= n_update + 1;
      upd_cyc  <= cyc;
    end
    if (frame_done) begin
      n_done       <= n_done + 1;
      done_cyc     <= cyc;
      busy_at_done <= busy;
    end
    if (init && update) both_hi <= both_hi + 1;
  end

  int n_checks = 0;
  int n_fail = 0;
  int last_edge = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    sif.sample_valid = 1'b1;
    sif.sample_re    = re;
    sif.sample_im    = im;
    sif.sample_last  = last;
    tick(1);
    last_edge = cyc;
    sif.sample_valid = 1'b0;
    sif.sample_last  = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  int e2;

  initial begin
    sif.sample_valid = 1'b0;
    sif.sample_re    = '0;
    sif.sample_im    = '0;
    sif.sample_last  = 1'b0;
`ifdef BFP_BW_TRACKER_OVF_EN
    sif.sample_ovf   = 1'b0;
`endif
    tick(3);
    check("rst_init", init, 0);
    check("rst_update", update, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_bw_init", bw_init, 0);
    check("rst_bw_new", bw_new, 0);
    reset_n = 1'b1;
    tick(2);

    // samples while idle are ignored
    send(16'd5, 16'd0, 1'b1);
    tick(4);
    check("idle_init", n_init, 0);
    check("idle_update", n_update, 0);
    check("idle_busy", busy, 0);

    // ADC pass: widths 0, 9, 15 -> 15
    pulse_start();
    check("adc_busy", busy, 1);
    send(16'h0000, 16'hFFFF, 1'b0);
    send(16'h0100, 16'h0005, 1'b0);
    send(16'h0003, 16'h8000, 1'b1);
    tick(3);
    check("adc_init_cnt", n_init, 1);
    check("adc_bw_init", bw_init, 15);
    check("adc_latency", init_cyc, last_edge + 2);
    check("adc_no_update", n_update, 0);

    // abort one cycle after sample_last, coincident sample discarded
    send(16'h7FFF, 16'h0000, 1'b1);
    frame_start      = 1'b1;
    sif.sample_valid = 1'b1;
    sif.sample_re    = 16'h4000;
    sif.sample_last  = 1'b1;
    tick(1);
    frame_start      = 1'b0;
    sif.sample_valid = 1'b0;
    sif.sample_last  = 1'b0;
    tick(4);
    check("abort_no_update", n_update, 0);
    check("abort_no_init", n_init, 1);
    check("abort_busy", busy, 1);
    send(16'h0001, 16'h0000, 1'b1);
    tick(3);
    check("abort_new_init_cnt", n_init, 2);
    check("abort_new_bw_init", bw_init, 1);

    // full frame, back-to-back passes with maxima 9, 4, 0
    pulse_start();
    send(16'h0100, 16'h0000, 1'b0);
    send(16'hFFFE, 16'h0001, 1'b1);
    send(16'h0001, 16'hFFF7, 1'b0);
    send(16'hFFFF, 16'h0003, 1'b1);
    send(16'h0000, 16'hFFFF, 1'b1);
    e2 = last_edge;
    tick(4);
    check("frame_init_cnt", n_init, 3);
    check("frame_bw_init", bw_init, 9);
    check("frame_update_cnt", n_update, 2);
    check("frame_upd0", upd_val[0], 4);
    check("frame_upd1", upd_val[1], 0);
    check("frame_bw_new", bw_new, 0);
    check("frame_done_cnt", n_done, 1);
    check("frame_done_cyc", done_cyc, e2 + 2);
    check("frame_upd_cyc", upd_cyc, e2 + 2);
    check("frame_busy_at_done", busy_at_done, 0);
    check("frame_busy_after", busy, 0);
    check("frame_init_update_overlap", both_hi, 0);

    // overflow flag on a width-1 sample
    pulse_start();
`ifdef BFP_BW_TRACKER_OVF_EN
    sif.sample_ovf = 1'b1;
`endif
    send(16'h0001, 16'h0000, 1'b1);
`ifdef BFP_BW_TRACKER_OVF_EN
    sif.sample_ovf = 1'b0;
`endif
    tick(3);
    check("ovf_init_cnt", n_init, 4);
`ifdef BFP_BW_TRACKER_OVF_EN
    check("ovf_bw_init", bw_init, 16);
`else
    check("ovf_bw_init", bw_init, 1);
`endif

    // reset with a last sample in flight
    sif.sample_valid = 1'b1;
    sif.sample_re    = 16'h7FFF;
    sif.sample_last  = 1'b1;
    tick(1);
    reset_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_init", init, 0);
    check("mrst_update", update, 0);
    check("mrst_bw_init", bw_init, 0);
    check("mrst_bw_new", bw_new, 0);
    sif.sample_valid = 1'b0;
    sif.sample_last  = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("mrst_no_init", n_init, 4);
    check("mrst_no_update", n_update, 2);
    check("mrst_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
